// File: rtl/frame_player.sv
// Plays a stored frame back from SDRAM as JAMMA-style video (pixel_clock, rgb, hsync, vsync).
// A 4-deep pixel FIFO is kept topped up with at most one SDRAM read in flight.
module frame_player #(
  parameter int          H_ACTIVE  = 30,
  parameter int          H_SYNC    = 3,
  parameter int          V_ACTIVE  = 20,
  parameter int          V_SYNC    = 2,
  parameter int          CLK_DIV   = 10,
  parameter logic [22:0] BASE_ADDR = 23'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [22:0] addr,
  output logic        rw,
  output logic        in_valid,
  input  logic        busy,
  input  logic [31:0] data_out,
  input  logic        out_valid,
  output logic        pixel_clock,
  output logic [7:0]  r,
  output logic [7:0]  g,
  output logic [7:0]  b,
  output logic        hsync,
  output logic        vsync,
  output logic [1:0]  state,
  output logic        underrun
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FILL = 2'd1;
  localparam logic [1:0] S_PLAY = 2'd2;
  localparam logic [1:0] S_STOP = 2'd3;

  localparam int H_TOTAL = H_ACTIVE + H_SYNC;
  localparam int V_TOTAL = V_ACTIVE + V_SYNC;
  localparam int PW      = $clog2(H_TOTAL);
  localparam int LW      = $clog2(V_TOTAL);
  localparam int DW      = $clog2(2 * CLK_DIV);
  localparam logic [22:0] LAST_ADDR = BASE_ADDR + 23'(H_ACTIVE * V_ACTIVE - 1);

  logic [23:0]   fifo_mem [4];
  logic [1:0]    wr_ptr, rd_ptr;
  logic [2:0]    fifo_count;
  logic          outstanding;
  logic [22:0]   ptr;
  logic [DW-1:0] div;
  logic [PW-1:0] pixel, nxt_pixel, show_pixel;
  logic [LW-1:0] line, nxt_line, show_line;
  logic          engine_on, accept, resp, push, pop, wrap;
  logic          last_pix, last_line, stop_now, load, show_active, fifo_empty;
  logic          unused_bits;

  assign rw          = 1'b0;
  assign unused_bits = ^data_out[31:24];

  always_comb begin
    engine_on   = (state == S_FILL) || (state == S_PLAY);
    accept      = in_valid && !busy;
    resp        = outstanding && out_valid;
    push        = resp && engine_on;
    fifo_empty  = (fifo_count == 3'd0);
    wrap        = (div == DW'(2 * CLK_DIV - 1));
    last_pix    = (pixel == PW'(H_TOTAL - 1));
    last_line   = (line == LW'(V_TOTAL - 1));
    nxt_pixel   = last_pix ? '0 : pixel + PW'(1);
    nxt_line    = line;
    if (last_pix) nxt_line = last_line ? '0 : line + LW'(1);
    stop_now    = (state == S_PLAY) && wrap && last_pix && last_line && !start;
    // The first pixel is registered on the FILL->PLAY edge, later ones on each divider wrap.
    load        = ((state == S_FILL) && (fifo_count == 3'd4)) ||
                  ((state == S_PLAY) && wrap && !stop_now);
    show_pixel  = (state == S_FILL) ? '0 : nxt_pixel;
    show_line   = (state == S_FILL) ? '0 : nxt_line;
    show_active = (show_line < LW'(V_ACTIVE)) && (show_pixel < PW'(H_ACTIVE));
    pop         = load && show_active && !fifo_empty;
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= data_out[23:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      addr        <= '0;
      in_valid    <= 1'b0;
      outstanding <= 1'b0;
      ptr         <= BASE_ADDR;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_count  <= '0;
      div         <= '0;
      pixel       <= '0;
      line        <= '0;
      pixel_clock <= 1'b0;
      r           <= '0;
      g           <= '0;
      b           <= '0;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      if (accept) begin
        in_valid    <= 1'b0;
        outstanding <= 1'b1;
        ptr         <= (ptr == LAST_ADDR) ? BASE_ADDR : ptr + 23'd1;
      end else if (engine_on && !in_valid && !outstanding && fifo_count < 3'd4) begin
        in_valid <= 1'b1;
        addr     <= ptr;
      end
      if (resp) outstanding <= 1'b0;

      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      if (push && !pop)      fifo_count <= fifo_count + 3'd1;
      else if (pop && !push) fifo_count <= fifo_count - 3'd1;

      if (load) begin
        r     <= pop ? fifo_mem[rd_ptr][23:16] : 8'd0;
        g     <= pop ? fifo_mem[rd_ptr][15:8]  : 8'd0;
        b     <= pop ? fifo_mem[rd_ptr][7:0]   : 8'd0;
        hsync <= (show_pixel >= PW'(H_ACTIVE));
        vsync <= (show_line >= LW'(V_ACTIVE));
        if (show_active && fifo_empty) underrun <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_FILL;
            ptr      <= BASE_ADDR;
            underrun <= 1'b0;
          end
        end
        S_FILL: begin
          if (fifo_count == 3'd4) begin
            state       <= S_PLAY;
            div         <= '0;
            pixel       <= '0;
            line        <= '0;
            pixel_clock <= 1'b0;
          end
        end
        S_PLAY: begin
          if (stop_now) begin
            in_valid    <= 1'b0;
            addr        <= '0;
            div         <= '0;
            pixel       <= '0;
            line        <= '0;
            pixel_clock <= 1'b0;
            r           <= '0;
            g           <= '0;
            b           <= '0;
            hsync       <= 1'b0;
            vsync       <= 1'b0;
            // A read accepted or still in flight must drain before IDLE.
            if (accept || (outstanding && !resp)) begin
              state <= S_STOP;
            end else begin
              state      <= S_IDLE;
              ptr        <= BASE_ADDR;
              wr_ptr     <= '0;
              rd_ptr     <= '0;
              fifo_count <= '0;
            end
          end else begin
            div         <= wrap ? '0 : div + DW'(1);
            pixel_clock <= !wrap && ((div + DW'(1)) >= DW'(CLK_DIV));
            if (wrap) begin
              pixel <= nxt_pixel;
              line  <= nxt_line;
            end
          end
        end
        default: begin
          if (resp) begin
            state      <= S_IDLE;
            ptr        <= BASE_ADDR;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_player.sv
// Directed bench for frame_player: SDRAM model with 3 busy cycles per request and 5-cycle read latency.
module tb_frame_player;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        busy = 1'b0;
  logic        out_valid = 1'b0;
  logic [31:0] data_out = '0;
  logic [22:0] addr;
  logic        rw, in_valid, pixel_clock, hsync, vsync, underrun;
  logic [7:0]  r, g, b;
  logic [1:0]  state;

  frame_player dut (
    .clk(clk), .rst(rst), .start(start), .addr(addr), .rw(rw), .in_valid(in_valid),
    .busy(busy), .data_out(data_out), .out_valid(out_valid), .pixel_clock(pixel_clock),
    .r(r), .g(g), .b(b), .hsync(hsync), .vsync(vsync), .state(state), .underrun(underrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;
  int bcnt = 0;
  int lat = 0;
  int overlap = 0;
  logic        force_busy = 1'b0;
  logic [22:0] acc_addr = '0;
  logic [22:0] acc_log [$];

  // Memory model: decisions made on the falling edge, sampled by the DUT on the next rising edge.
  initial forever begin
    @(negedge clk);
    out_valid = 1'b0;
    if (lat > 0) begin
      lat--;
      if (lat == 0) begin
        out_valid = 1'b1;
        data_out  = {8'h00, acc_addr[7:0], acc_addr[7:0] + 8'd1, acc_addr[7:0] + 8'd2};
      end
    end
    if (force_busy) begin
      busy = 1'b1;
    end else if (in_valid && rst) begin
      if (bcnt < 3) begin
        busy = 1'b1;
        bcnt++;
      end else begin
        busy = 1'b0;
        bcnt = 0;
        if (lat > 0) overlap++;
        lat      = 5;
        acc_addr = addr;
        acc_log.push_back(addr);
      end
    end else begin
      busy = 1'b0;
      bcnt = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic goto(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_state(input logic [1:0] exp, input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (state == exp) break;
    end
    chk(tag, 32'(state), 32'(exp));
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  int c0, f0, f1;
  logic found;

  initial begin
    rst   = 1'b0;
    start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctrl", 32'({in_valid, rw, pixel_clock, hsync, vsync, underrun, state}), 32'd0);
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_rgb", 32'({r, g, b}), 32'd0);

    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("fill_entry", 32'(state), 32'd1);
    for (int i = 0; i < 5; i++) begin
      if (in_valid) break;
      @(posedge clk);
      #1;
    end
    chk("first_req", 32'({in_valid, rw, addr}), 32'({1'b1, 1'b0, 23'd0}));

    wait_state(2'd2, 500, "play_entry");
    c0 = cyc;
    chk("fill_reads", 32'(acc_log.size()), 32'd4);
    for (int i = 0; i < acc_log.size() && i < 4; i++) chk("fill_addr", 32'(acc_log[i]), 32'(i));
    chk("one_outstanding", 32'(overlap), 32'd0);
    chk("px0_rgb", 32'({r, g, b}), 32'h000102);
    chk("px0_pclk", 32'({pixel_clock, hsync, vsync}), 32'd0);

    goto(c0 + 9);
    chk("px0_low_half", 32'({pixel_clock, r, g, b}), 32'h0_000102);
    goto(c0 + 10);
    chk("pclk_rise", 32'({pixel_clock, r, g, b}), 32'h1_000102);
    goto(c0 + 19);
    chk("pclk_high_hold", 32'({pixel_clock, r, g, b}), 32'h1_000102);
    goto(c0 + 20);
    chk("px1", 32'({pixel_clock, r, g, b}), 32'h0_010203);
    goto(c0 + 580);
    chk("px29", 32'({hsync, r, g, b}), 32'h0_1d1e1f);
    goto(c0 + 600);
    chk("hsync_start", 32'({hsync, vsync, r, g, b}), 32'h2_000000);
    goto(c0 + 659);
    chk("hsync_end", 32'({hsync, vsync, r, g, b}), 32'h2_000000);
    goto(c0 + 660);
    chk("line1_px0", 32'({hsync, vsync, r, g, b}), 32'h0_1e1f20);
    goto(c0 + 13120);
    chk("last_active_px", 32'({hsync, vsync, r, g, b}), 32'h0_575859);
    goto(c0 + 13200);
    chk("vsync_start", 32'({hsync, vsync, r, g, b}), 32'h1_000000);
    goto(c0 + 13800);
    chk("vsync_hsync", 32'({hsync, vsync, r, g, b}), 32'h3_000000);
    goto(c0 + 14519);
    chk("vsync_end", 32'({hsync, vsync, r, g, b}), 32'h3_000000);
    goto(c0 + 14520);
    chk("frame2_wrap", 32'({hsync, vsync, r, g, b}), 32'h0_000102);
    chk("no_underrun", 32'(underrun), 32'd0);

    f0 = c0 + 14520;
    goto(f0 + 99);
    @(negedge clk);
    force_busy = 1'b1;
    goto(f0 + 1100);
    chk("starved_rgb", 32'({hsync, vsync, r, g, b}), 32'h0_000000);
    chk("underrun_set", 32'(underrun), 32'd1);
    goto(f0 + 2099);
    @(negedge clk);
    force_busy = 1'b0;
    goto(f0 + 14519);
    chk("underrun_sticky", 32'(underrun), 32'd1);

    f1 = c0 + 29040;
    goto(f1 + 5 * 660);
    @(negedge clk);
    start = 1'b0;
    goto(f1 + 14519);
    chk("stop_finishes_frame", 32'(state), 32'd2);
    wait_state(2'd0, 20, "stop_idle");
    chk("stop_outputs", 32'({pixel_clock, hsync, vsync, in_valid, r, g, b}), 32'd0);
    chk("underrun_kept_idle", 32'(underrun), 32'd1);

    @(negedge clk);
    start = 1'b1;
    wait_state(2'd1, 5, "restart_fill");
    chk("underrun_cleared", 32'(underrun), 32'd0);
    wait_state(2'd2, 500, "replay");
    chk("replay_px0", 32'({r, g, b}), 32'h000102);

    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (lat == 3) begin
        found = 1'b1;
        break;
      end
    end
    chk("read_in_flight", 32'(found), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_ctrl", 32'({in_valid, rw, pixel_clock, hsync, vsync, underrun, state}), 32'd0);
    chk("async_rst_data", 32'({addr, r, g, b}), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    wait_state(2'd2, 500, "post_rst_play");
    chk("post_rst_px0", 32'({r, g, b}), 32'h000102);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
